// File: rtl/gfsk_bit_slicer_if.sv
// Sample-in / bit-out bundle for the GFSK bit slicer.
// The master side feeds soft samples and receives recovered bits; the slicer is the slave.
interface gfsk_bit_slicer_if #(
    parameter int unsigned DW = 11
) ();
    logic          clear;
    logic [DW-1:0] sample_in;
    logic          sample_vld;
    logic          bit_out;
    logic          bit_vld;
    logic          locked;
    logic [7:0]    phase_err;

    modport master (
        output clear,
        output sample_in,
        output sample_vld,
        input  bit_out,
        input  bit_vld,
        input  locked,
        input  phase_err
    );

    modport slave (
        input  clear,
        input  sample_in,
        input  sample_vld,
        output bit_out,
        output bit_vld,
        output locked,
        output phase_err
    );
endinterface

// File: rtl/gfsk_bit_slicer.sv
// GFSK hard slicer with zero-crossing symbol timing recovery and lock detection.
// Define ADAPTIVE_THRESH_EN to replace the fixed MID threshold with a DC-tracking IIR.
module gfsk_bit_slicer #(
    parameter int unsigned DW       = 11,
    parameter int unsigned SPS      = 8,
    parameter int unsigned MID      = 400,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned ERR_TOL  = 1,
    parameter int unsigned MAX_RUN  = 32
) (
    input logic              clk,
    input logic              rst_n,
    gfsk_bit_slicer_if.slave bus
);
    localparam int unsigned PhW  = $clog2(SPS);
    localparam int unsigned Half = SPS / 2;
    localparam int unsigned CntW = $clog2(LOCK_CNT + 1);
    localparam int unsigned RunW = $clog2(MAX_RUN + 1);

    typedef enum logic [1:0] {
        StSearch,
        StTrack,
        StLocked
    } state_e;

    state_e          state_q, state_d;
    logic [PhW-1:0]  ph_q, ph_d;
    logic            s_prev_q, s_prev_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      miss_q, miss_d;
    logic [RunW-1:0] run_q, run_d;
    logic            bit_out_q, bit_out_d;
    logic            bit_vld_q, bit_vld_d;
    logic [7:0]      phase_err_q, phase_err_d;

    logic [DW-1:0]   thr;

`ifdef ADAPTIVE_THRESH_EN
    localparam int unsigned AccW = DW + 5;

    logic [AccW-1:0] acc_q, acc_d;

    // First-order IIR with a 32-sample time constant; thr is the integer part.
    assign thr = acc_q[AccW-1:5];

    always_comb begin
        acc_d = acc_q;
        if (bus.sample_vld) begin
            acc_d = acc_q + AccW'(bus.sample_in) - (acc_q >> 5);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            acc_q <= AccW'(MID) << 5;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign thr = DW'(MID);
`endif

    logic            s;
    logic            trans;
    logic            in_tol;
    logic [PhW-1:0]  ph_inc;
    logic [PhW-1:0]  ph_corr;
    logic [PhW:0]    ph_plus2;
    logic [8:0]      err;
    logic [8:0]      err_abs;
    logic [CntW-1:0] cnt_inc;
    logic [1:0]      miss_inc;
    logic [RunW-1:0] run_inc;

    always_comb begin
        s        = (bus.sample_in >= thr);
        trans    = (s != s_prev_q);
        ph_inc   = (ph_q == PhW'(SPS - 1)) ? '0 : ph_q + 1'b1;
        ph_plus2 = {1'b0, ph_q} + (PhW + 1)'(2);
        err      = (ph_q < PhW'(Half)) ? 9'(ph_q) : 9'(ph_q) - 9'(SPS);
        err_abs  = err[8] ? 9'd0 - err : err;
        in_tol   = (err_abs <= 9'(ERR_TOL));
        cnt_inc  = cnt_q + 1'b1;
        miss_inc = miss_q + 1'b1;
        run_inc  = run_q + 1'b1;

        // Late edges hold the phase for one sample; early edges skip one ahead.
        if (ph_q == '0) begin
            ph_corr = ph_inc;
        end else if (ph_q < PhW'(Half)) begin
            ph_corr = ph_q;
        end else if (ph_plus2 >= (PhW + 1)'(SPS)) begin
            ph_corr = PhW'(ph_plus2 - (PhW + 1)'(SPS));
        end else begin
            ph_corr = PhW'(ph_plus2);
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        s_prev_d    = s_prev_q;
        cnt_d       = cnt_q;
        miss_d      = miss_q;
        run_d       = run_q;
        bit_out_d   = bit_out_q;
        bit_vld_d   = 1'b0;
        phase_err_d = phase_err_q;

        if (bus.sample_vld) begin
            s_prev_d = s;
            ph_d     = ph_inc;

            // The bit is decided before any phase correction from the same sample.
            if (state_q != StSearch && ph_q == PhW'(Half)) begin
                bit_out_d = s;
                bit_vld_d = 1'b1;
            end

            if (trans) begin
                phase_err_d = err[7:0];
                run_d       = '0;
                case (state_q)
                    StSearch: begin
                        ph_d    = PhW'(1);
                        state_d = StTrack;
                        cnt_d   = '0;
                    end
                    StTrack: begin
                        ph_d = ph_corr;
                        if (in_tol) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CntW'(LOCK_CNT)) begin
                                state_d = StLocked;
                                miss_d  = '0;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    StLocked: begin
                        ph_d = ph_corr;
                        if (in_tol) begin
                            miss_d = '0;
                        end else if (miss_inc == 2'd2) begin
                            state_d = StTrack;
                            cnt_d   = '0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end
                    default: begin
                        state_d = StSearch;
                    end
                endcase
            end else if (state_q != StSearch && ph_q == PhW'(SPS - 1)) begin
                // Symbol wrap without an edge: too many in a row means timing is lost.
                if (run_inc == RunW'(MAX_RUN)) begin
                    state_d = StSearch;
                    run_d   = '0;
                end else begin
                    run_d = run_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.clear) begin
            state_q     <= StSearch;
            ph_q        <= '0;
            s_prev_q    <= 1'b0;
            cnt_q       <= '0;
            miss_q      <= '0;
            run_q       <= '0;
            bit_out_q   <= 1'b0;
            bit_vld_q   <= 1'b0;
            phase_err_q <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            s_prev_q    <= s_prev_d;
            cnt_q       <= cnt_d;
            miss_q      <= miss_d;
            run_q       <= run_d;
            bit_out_q   <= bit_out_d;
            bit_vld_q   <= bit_vld_d;
            phase_err_q <= phase_err_d;
        end
    end

    assign bus.bit_out   = bit_out_q;
    assign bus.bit_vld   = bit_vld_q;
    assign bus.locked    = (state_q == StLocked);
    assign bus.phase_err = phase_err_q;
endmodule
